// File: rtl/twire_slave_model_if.sv
// Two-wire serial bus signals between the master-side bench/loopback and the slave model.
// SDA is open-drain: the slave only reports whether it pulls the line low.
interface twire_slave_model_if;
    logic        scl;
    logic        sda_i;
    logic        sda_oe;
    logic        busy;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        error;

    modport slave (
        input  scl, sda_i,
        output sda_oe, busy, wr_valid, wr_addr, wr_data, error
    );

    modport master (
        output scl, sda_i,
        input  sda_oe, busy, wr_valid, wr_addr, wr_data, error
    );
endinterface

// File: rtl/twire_slave_model.sv
// Two-wire register slave: 7-bit device address, 16-bit register pointer, 16-bit data words.
// Define TWIRE_SLAVE_AUTOINC_EN for burst reads/writes with pointer auto-increment.
module twire_slave_model #(
    parameter logic [6:0]  DEV_ADDR = 7'h48,
    parameter int unsigned REG_AW   = 4
) (
    input logic                clk,
    input logic                async_rst,
    twire_slave_model_if.slave bus
);

    typedef enum logic [3:0] {
        StIdle, StDev, StDevAck, StRaHi, StRaHiAck, StRaLo, StRaLoAck, StWdHi,
        StWdHiAck, StWdLo, StWdLoAck, StRdHi, StRdHiMack, StRdLo, StRdLoMack, StIgnore
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  scl_q, sda_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_hi_q, data_hi_d;
    logic [7:0]  tx_q, tx_d;
    logic [15:0] ptr_q, ptr_d;
    logic        ph_q, ph_d;
    logic        rw_q, rw_d;
    logic        sda_oe_q, sda_oe_d;
    logic        wr_valid_q, wr_valid_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        error_q, error_d;
    logic [15:0] bank_q [2**REG_AW];

    logic        scl_rise, scl_fall, start_det, stop_det, sda_s;
    logic        rx_st, ack_st, tx_st, mack_st, rx_done, ack_end, bank_we;
    logic [7:0]  byte_in;
    logic [15:0] rd_addr, rd_data;
    logic        rd_in_range, wr_in_range;

    // q[0]/q[1] synchronize, q[2] is the history flop used for edge detection.
    assign sda_s     = sda_q[1];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign byte_in   = {shift_q[6:0], sda_s};

    assign rx_st   = state_q inside {StDev, StRaHi, StRaLo, StWdHi, StWdLo};
    assign ack_st  = state_q inside {StDevAck, StRaHiAck, StRaLoAck, StWdHiAck, StWdLoAck};
    assign tx_st   = state_q inside {StRdHi, StRdLo};
    assign mack_st = state_q inside {StRdHiMack, StRdLoMack};

`ifdef TWIRE_SLAVE_AUTOINC_EN
    logic [15:0] ptr_inc;
    assign ptr_inc = ptr_q + 16'd1;
    // A burst read fetches the next word while the pointer advances.
    assign rd_addr = (state_q == StRdLoMack) ? ptr_inc : ptr_q;
`else
    assign rd_addr = ptr_q;
`endif

    assign rd_in_range = (rd_addr >> REG_AW) == 16'd0;
    assign wr_in_range = (ptr_q >> REG_AW) == 16'd0;
    assign rd_data     = rd_in_range ? bank_q[rd_addr[REG_AW-1:0]] : 16'h0000;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_hi_d  = data_hi_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        ph_d       = ph_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        error_d    = 1'b0;
        bank_we    = 1'b0;
        rx_done    = 1'b0;
        ack_end    = 1'b0;
        if (start_det) begin
            state_d   = StDev;
            bit_cnt_d = 3'd0;
            ph_d      = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
        end else begin
            if (rx_st && scl_rise) begin
                shift_d   = byte_in;
                bit_cnt_d = bit_cnt_q + 3'd1;
                rx_done   = (bit_cnt_q == 3'd7);
            end
            // 9th-bit period: ph_q marks that its rising edge has been seen.
            if (ack_st || mack_st) begin
                if (scl_fall && !ph_q) sda_oe_d = ack_st;
                if (scl_rise) ph_d = 1'b1;
                if (scl_fall && ph_q) begin
                    sda_oe_d = 1'b0;
                    ph_d     = 1'b0;
                    ack_end  = 1'b1;
                end
            end
            if (tx_st) begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = (state_q == StRdHi) ? StRdHiMack : StRdLoMack;
                end
                if (scl_fall) begin
                    tx_d     = {tx_q[6:0], 1'b0};
                    sda_oe_d = ~tx_q[6];
                end
            end
            case (state_q)
                StDev: if (rx_done) begin
                    rw_d    = sda_s;
                    state_d = (shift_q[6:0] == DEV_ADDR) ? StDevAck : StIgnore;
                end
                StRaHi: if (rx_done) begin
                    ptr_d[15:8] = byte_in;
                    state_d     = StRaHiAck;
                end
                StRaLo: if (rx_done) begin
                    ptr_d[7:0] = byte_in;
                    state_d    = StRaLoAck;
                end
                StWdHi: if (rx_done) begin
                    data_hi_d = byte_in;
                    state_d   = StWdHiAck;
                end
                StWdLo:    if (rx_done) state_d = StWdLoAck;
                StRaHiAck: if (ack_end) state_d = StRaLo;
                StRaLoAck: if (ack_end) state_d = StWdHi;
                StWdHiAck: if (ack_end) state_d = StWdLo;
                StDevAck: if (ack_end) begin
                    state_d = rw_q ? StRdHi : StRaHi;
                    if (rw_q) begin
                        tx_d     = rd_data[15:8];
                        sda_oe_d = ~rd_data[15];
                        error_d  = ~rd_in_range;
                    end
                end
                StWdLoAck: begin
                    if (scl_rise) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = ptr_q;
                        wr_data_d  = {data_hi_q, shift_q};
                        bank_we    = wr_in_range;
                        error_d    = ~wr_in_range;
                    end
                    if (ack_end) begin
`ifdef TWIRE_SLAVE_AUTOINC_EN
                        ptr_d   = ptr_inc;
                        state_d = StWdHi;
`else
                        state_d = StIgnore;
`endif
                    end
                end
                StRdHiMack: begin
                    if (scl_rise && sda_s) begin
                        error_d = 1'b1;
                        state_d = StIgnore;
                    end
                    if (ack_end) begin
                        tx_d     = rd_data[7:0];
                        sda_oe_d = ~rd_data[7];
                        state_d  = StRdLo;
                    end
                end
                StRdLoMack: begin
                    if (scl_rise && sda_s) state_d = StIgnore;
                    if (ack_end) begin
`ifdef TWIRE_SLAVE_AUTOINC_EN
                        ptr_d = ptr_inc;
`endif
                        tx_d     = rd_data[15:8];
                        sda_oe_d = ~rd_data[15];
                        error_d  = ~rd_in_range;
                        state_d  = StRdHi;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            scl_q      <= 3'b111;
            sda_q      <= 3'b111;
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            data_hi_q  <= 8'h00;
            tx_q       <= 8'h00;
            ptr_q      <= 16'h0000;
            ph_q       <= 1'b0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 16'h0000;
            wr_data_q  <= 16'h0000;
            error_q    <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++) bank_q[i] <= 16'h0000;
        end else begin
            scl_q      <= {scl_q[1:0], bus.scl};
            sda_q      <= {sda_q[1:0], bus.sda_i};
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_hi_q  <= data_hi_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            ph_q       <= ph_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            error_q    <= error_d;
            if (bank_we) bank_q[ptr_q[REG_AW-1:0]] <= wr_data_d;
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.busy     = (state_q != StIdle) && (state_q != StIgnore);
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_twire_slave_model.sv
// Directed bench for twire_slave_model: bit-banged master with open-drain SDA resolution.
module tb_twire_slave_model;
    localparam int Q = 8;  // SCL half-period in clk cycles

    logic clk = 1'b0;
    logic async_rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    int total = 0;
    int bad = 0;
    int wv_cnt = 0;
    int err_cnt = 0;
    int oe_cnt = 0;
    logic [15:0] wv_addr = 16'h0;
    logic [15:0] wv_prev_addr = 16'h0;
    logic [15:0] wv_data = 16'h0;

    twire_slave_model_if bus ();
    assign bus.scl   = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    twire_slave_model #(.DEV_ADDR(7'h48), .REG_AW(4)) dut (
        .clk       (clk),
        .async_rst (async_rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_valid) begin
            wv_cnt++;
            wv_prev_addr = wv_addr;
            wv_addr = bus.wr_addr;
            wv_data = bus.wr_data;
        end
        if (bus.error) err_cnt++;
        if (bus.sda_oe) oe_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1; clks(Q);
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic do_stop();
        sda_m = 1'b0; clks(Q);
        scl_m = 1'b1; clks(Q);
        sda_m = 1'b1; clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic nack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; clks(Q);
            scl_m = 1'b1; clks(Q);
            scl_m = 1'b0;
        end
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1; clks(Q / 2);
        nack = bus.sda_i;
        clks(Q / 2);
        scl_m = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic nack);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            clks(Q);
            scl_m = 1'b1; clks(Q / 2);
            b[i] = bus.sda_i;
            clks(Q / 2);
            scl_m = 1'b0;
        end
        sda_m = nack; clks(Q);
        scl_m = 1'b1; clks(Q);
        scl_m = 1'b0;
    endtask

    task automatic write_word(input logic [15:0] a, input logic [15:0] d, output logic [4:0] nk);
        do_start();
        send_byte(8'h90, nk[4]);
        send_byte(a[15:8], nk[3]);
        send_byte(a[7:0], nk[2]);
        send_byte(d[15:8], nk[1]);
        send_byte(d[7:0], nk[0]);
        do_stop();
    endtask

    task automatic read_n(input logic [15:0] a, input int n, output logic [31:0] d,
                          output logic [3:0] nk);
        logic [7:0] b;
        d = 32'h0;
        do_start();
        send_byte(8'h90, nk[3]);
        send_byte(a[15:8], nk[2]);
        send_byte(a[7:0], nk[1]);
        do_start();
        send_byte(8'h91, nk[0]);
        for (int i = 0; i < n; i++) begin
            recv_byte(b, (i == n - 1));
            d = {d[23:0], b};
        end
        do_stop();
    endtask

    task automatic test_reset();
        logic [4:0] nk;
        logic [3:0] rk;
        logic [31:0] d;
        logic [7:0] b;
        clks(3);
        total++;
        if (bus.sda_oe !== 1'b0 || bus.busy !== 1'b0 || bus.wr_valid !== 1'b0 ||
            bus.error !== 1'b0 || bus.wr_addr !== 16'h0 || bus.wr_data !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs: got oe=%b busy=%b wv=%b err=%b addr=%h data=%h, want 0",
                     bus.sda_oe, bus.busy, bus.wr_valid, bus.error, bus.wr_addr, bus.wr_data);
        end
        async_rst = 1'b0;
        clks(4);
        write_word(16'h0002, 16'h55AA, nk);
        read_n(16'h0002, 2, d, rk);
        total++;
        if (d[15:0] !== 16'h55AA) begin
            bad++;
            $display("FAIL pre_reset_readback: got %h want 55aa", d[15:0]);
        end
        do_start();
        b = 8'h90;
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; clks(Q);
            scl_m = 1'b1; clks(Q);
            scl_m = 1'b0;
        end
        sda_m = 1'b1;
        clks(6);
        total++;
        if (bus.sda_oe !== 1'b1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL ack_before_reset: got oe=%b busy=%b want 1 1", bus.sda_oe, bus.busy);
        end
        async_rst = 1'b1;
        #1;
        total++;
        if (bus.sda_oe !== 1'b0 || bus.busy !== 1'b0 || bus.wr_addr !== 16'h0 ||
            bus.wr_data !== 16'h0) begin
            bad++;
            $display("FAIL async_reset: got oe=%b busy=%b addr=%h data=%h want 0 0 0000 0000",
                     bus.sda_oe, bus.busy, bus.wr_addr, bus.wr_data);
        end
        clks(2);
        async_rst = 1'b0;
        clks(2);
        do_stop();
        read_n(16'h0002, 2, d, rk);
        total++;
        if (d[15:0] !== 16'h0000 || rk !== 4'b0000) begin
            bad++;
            $display("FAIL bank_cleared: got %h nacks=%b want 0000 0000", d[15:0], rk);
        end
    endtask

    task automatic test_write();
        logic [4:0] nk;
        int w0;
        w0 = wv_cnt;
        do_start();
        send_byte(8'h90, nk[4]);
        send_byte(8'h00, nk[3]);
        send_byte(8'h03, nk[2]);
        send_byte(8'hAB, nk[1]);
        send_byte(8'hCD, nk[0]);
        total++;
        if (nk !== 5'b00000) begin
            bad++;
            $display("FAIL write_acks: got nacks=%b want 00000", nk);
        end
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_during: got %b want 1", bus.busy);
        end
        total++;
        if (wv_cnt !== w0 + 1 || wv_addr !== 16'h0003 || wv_data !== 16'hABCD) begin
            bad++;
            $display("FAIL write_commit: got cnt=%0d addr=%h data=%h want %0d 0003 abcd",
                     wv_cnt - w0, wv_addr, wv_data, 1);
        end
        do_stop();
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_stop: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_read();
        logic [3:0] rk;
        logic [31:0] d;
        int e0;
        e0 = err_cnt;
        read_n(16'h0003, 2, d, rk);
        total++;
        if (d[15:0] !== 16'hABCD || rk !== 4'b0000 || err_cnt !== e0) begin
            bad++;
            $display("FAIL read_back: got %h nacks=%b errs=%0d want abcd 0000 0",
                     d[15:0], rk, err_cnt - e0);
        end
    endtask

    task automatic test_wrong_dev();
        logic n;
        logic [3:0] rest;
        logic [3:0] rk;
        logic [31:0] d;
        int w0, o0;
        w0 = wv_cnt;
        o0 = oe_cnt;
        do_start();
        send_byte(8'h92, n);
        send_byte(8'h00, rest[3]);
        send_byte(8'h03, rest[2]);
        send_byte(8'h11, rest[1]);
        send_byte(8'h22, rest[0]);
        total++;
        if (n !== 1'b1 || rest !== 4'b1111) begin
            bad++;
            $display("FAIL wrong_dev_nack: got %b %b want 1 1111", n, rest);
        end
        total++;
        if (oe_cnt !== o0 || wv_cnt !== w0) begin
            bad++;
            $display("FAIL wrong_dev_quiet: got oe_cycles=%0d wv=%0d want 0 0",
                     oe_cnt - o0, wv_cnt - w0);
        end
        do_stop();
        read_n(16'h0003, 2, d, rk);
        total++;
        if (d[15:0] !== 16'hABCD) begin
            bad++;
            $display("FAIL wrong_dev_bank: got %h want abcd", d[15:0]);
        end
    endtask

    task automatic test_out_of_range();
        logic [4:0] nk;
        logic [3:0] rk;
        logic [31:0] d;
        int w0, e0;
        w0 = wv_cnt;
        e0 = err_cnt;
        write_word(16'h0010, 16'h1234, nk);
        total++;
        if (nk !== 5'b00000 || wv_cnt !== w0 + 1 || wv_addr !== 16'h0010 || err_cnt !== e0 + 1) begin
            bad++;
            $display("FAIL oor_write: got nacks=%b wv=%0d addr=%h errs=%0d want 00000 1 0010 1",
                     nk, wv_cnt - w0, wv_addr, err_cnt - e0);
        end
        read_n(16'h0000, 2, d, rk);
        total++;
        if (d[15:0] !== 16'h0000) begin
            bad++;
            $display("FAIL oor_no_alias: got %h want 0000", d[15:0]);
        end
        read_n(16'h0010, 2, d, rk);
        total++;
        if (d[15:0] !== 16'h0000 || err_cnt !== e0 + 2) begin
            bad++;
            $display("FAIL oor_read: got %h errs=%0d want 0000 2", d[15:0], err_cnt - e0);
        end
    endtask

    task automatic test_burst();
        logic [3:0] rk;
        logic [31:0] d;
        int w0;
        w0 = wv_cnt;
`ifdef TWIRE_SLAVE_AUTOINC_EN
        begin
            logic [6:0] nk;
            do_start();
            send_byte(8'h90, nk[6]);
            send_byte(8'h00, nk[5]);
            send_byte(8'h05, nk[4]);
            send_byte(8'h11, nk[3]);
            send_byte(8'h11, nk[2]);
            send_byte(8'h22, nk[1]);
            send_byte(8'h22, nk[0]);
            do_stop();
            total++;
            if (nk !== 7'b0 || wv_cnt !== w0 + 2 || wv_prev_addr !== 16'h0005 ||
                wv_addr !== 16'h0006 || wv_data !== 16'h2222) begin
                bad++;
                $display("FAIL burst_write: got nacks=%b wv=%0d a0=%h a1=%h d=%h want 0 2 0005 0006 2222",
                         nk, wv_cnt - w0, wv_prev_addr, wv_addr, wv_data);
            end
            read_n(16'h0005, 4, d, rk);
            total++;
            if (d !== 32'h11112222) begin
                bad++;
                $display("FAIL burst_read: got %h want 11112222", d);
            end
        end
`else
        begin
            logic [5:0] nk;
            do_start();
            send_byte(8'h90, nk[5]);
            send_byte(8'h00, nk[4]);
            send_byte(8'h05, nk[3]);
            send_byte(8'h11, nk[2]);
            send_byte(8'h11, nk[1]);
            send_byte(8'h22, nk[0]);
            do_stop();
            total++;
            if (nk !== 6'b000001 || wv_cnt !== w0 + 1 || wv_addr !== 16'h0005 ||
                wv_data !== 16'h1111) begin
                bad++;
                $display("FAIL single_write: got nacks=%b wv=%0d addr=%h d=%h want 000001 1 0005 1111",
                         nk, wv_cnt - w0, wv_addr, wv_data);
            end
            read_n(16'h0005, 4, d, rk);
            total++;
            if (d !== 32'h11111111) begin
                bad++;
                $display("FAIL resend_read: got %h want 11111111", d);
            end
        end
`endif
    endtask

    task automatic test_abort();
        logic [3:0] nk;
        logic [7:0] b0, b1;
        int w0;
        w0 = wv_cnt;
        do_start();
        send_byte(8'h90, nk[3]);
        send_byte(8'h00, nk[2]);
        send_byte(8'h07, nk[1]);
        send_byte(8'h55, nk[0]);
        do_start();
        send_byte(8'h91, nk[0]);
        recv_byte(b0, 1'b0);
        recv_byte(b1, 1'b1);
        do_stop();
        total++;
        if ({b0, b1} !== 16'h0000 || nk !== 4'b0000 || wv_cnt !== w0) begin
            bad++;
            $display("FAIL abort_partial: got %h nacks=%b wv=%0d want 0000 0000 0",
                     {b0, b1}, nk, wv_cnt - w0);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrong_dev();
        test_out_of_range();
        test_burst();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
